div_unit: RTL

//  Multi-cycle integer divider for the EX stage; executes MIPS DIV/DIVU.

---
 rtl/mips_defs.sv | 32 +++
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared MIPS core definitions: divider state encoding, iteration count and
// the ALU op codes that decode into the divider's start/signed_div controls.
package mips_defs;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = DIV_WIDTH;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_DIV  = 4'd5,
    ALU_DIVU = 4'd6
  } alu_op_e;

  function automatic logic alu_is_div(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic logic alu_div_signed(input alu_op_e op);
    return op == ALU_DIV;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift out one quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_dvd,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_dvd,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // The shifted remainder keeps one extra bit: divisors above 2^(WIDTH-1)
  // would otherwise lose the remainder MSB before the compare.
  assign w_shift = {i_rem, i_dvd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_qbit  = ~w_diff[WIDTH];
  assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_dvd   = {i_dvd[WIDTH-2:0], o_qbit};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Produces {hi=remainder, lo=quotient} and stalls the front end while busy.
module div_unit
  import mips_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  output logic               stall,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e          r_state;
  logic [CNT_W-1:0]    r_count;
  logic [WIDTH-1:0]    r_rem;
  logic [WIDTH-1:0]    r_dvd;
  logic [WIDTH-1:0]    r_divisor;
  logic                r_sign_q;
  logic                r_sign_r;
  logic                r_ready;
  logic [2*WIDTH-1:0]  r_result;

  logic                w_a_neg;
  logic                w_b_neg;
  logic [WIDTH-1:0]    w_a_abs;
  logic [WIDTH-1:0]    w_b_abs;
  logic [WIDTH-1:0]    w_rem_next;
  logic [WIDTH-1:0]    w_dvd_next;
  logic                w_qbit;
  logic [WIDTH-1:0]    w_quot_fix;
  logic [WIDTH-1:0]    w_rem_fix;

  assign w_a_neg = signed_div & a[WIDTH-1];
  assign w_b_neg = signed_div & b[WIDTH-1];
  assign w_a_abs = w_a_neg ? (~a + WIDTH'(1)) : a;
  assign w_b_abs = w_b_neg ? (~b + WIDTH'(1)) : b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dvd     (r_dvd),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_dvd     (w_dvd_next),
    .o_qbit    (w_qbit)
  );

  // Sign fix-up uses the step outputs so the result lands on the last BUSY edge.
  assign w_quot_fix = r_sign_q ? (~w_dvd_next + WIDTH'(1)) : w_dvd_next;
  assign w_rem_fix  = r_sign_r ? (~w_rem_next + WIDTH'(1)) : w_rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DIV_IDLE;
      r_count   <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_divisor <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
    end else begin
      // NOTE: ready is registered and set on the edge into DONE, so it is high
      // for exactly the one cycle the FSM spends in DONE.
      r_ready <= 1'b0;
      if (annul) begin
        r_state <= DIV_IDLE;
        r_count <= '0;
      end else begin
        case (r_state)
          DIV_IDLE: begin
            if (start) begin
              if (b != '0) begin
                r_rem     <= '0;
                r_dvd     <= w_a_abs;
                r_divisor <= w_b_abs;
                r_sign_q  <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_sign_r  <= w_a_neg;
                r_count   <= '0;
                r_state   <= DIV_BUSY;
              end else begin
                r_result  <= {a, {WIDTH{1'b1}}};
                r_ready   <= 1'b1;
                r_state   <= DIV_DONE;
              end
            end
          end
          DIV_BUSY: begin
            r_rem   <= w_rem_next;
            r_dvd   <= w_dvd_next;
            r_count <= r_count + CNT_W'(1);
            if (r_count == CNT_W'(DIV_ITER - 1)) begin
              r_result <= {w_rem_fix, w_quot_fix};
              r_ready  <= 1'b1;
              r_state  <= DIV_DONE;
            end
          end
          DIV_DONE: r_state <= DIV_IDLE;
          default:  r_state <= DIV_IDLE;
        endcase
      end
    end
  end

  assign stall  = start & (r_state != DIV_DONE) & ~annul;
  assign ready  = r_ready;
  assign result = r_result;

endmodule
